tone_gen: RTL
=============

TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: number of consecutive clock edges an input value must be held before it is accepted; legal range 2..255.
REQ-002 clk  input  1  system clock, 100 MHz; all logic is on the rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 note_in  input  4  note code from the mode controller: 0 = rest, 1..7 = do..si, 8..15 = invalid.
REQ-005 octave_in  input  2  octave select: 00 = low, 01 = middle, 10 = high, 11 = middle.
REQ-006 enable  input  1  sound enable; 0 mutes the output.
REQ-007 speaker  output  1  square-wave buzzer drive, registered.
REQ-008 playing  output  1  registered; 1 while a tone is being driven.
REQ-009 cur_note  output  4  accepted note code, registered.
REQ-010 cur_octave  output  2  accepted octave, registered.

Function
REQ-011 The block SHALL sample {octave_in, note_in} on every edge and count consecutive edges at which the sample is unchanged.
REQ-012 A sample value is accepted on the STABLE_CYCLES-th consecutive edge at which it is sampled. Example: a value first sampled at edge k is accepted at edge k+STABLE_CYCLES-1.
REQ-013 Note codes 8..15 SHALL be accepted as 0 (rest).
REQ-014 When an accepted value differs from {cur_octave, cur_note}, the block SHALL, on the same edge, update cur_note and cur_octave, clear the divider counter, and drive speaker to 0.
REQ-015 When an accepted value equals the current value, the block SHALL take no action; the tone continues without a phase break.
REQ-016 The block SHALL have two states: IDLE and TONE.
REQ-017 IDLE -> TONE when enable=1 and cur_note is in 1..7. TONE -> IDLE when enable=0 or cur_note=0.
REQ-018 playing SHALL be 1 exactly while the state is TONE.
REQ-019 In IDLE, speaker SHALL be 0 and the divider counter SHALL be held at 0.
REQ-020 Middle-octave half-period counts (cycles) for notes 1..7 SHALL be 191113, 170262, 151686, 143173, 127551, 113636, 101239.
REQ-021 For the low octave, the half period SHALL be the middle-octave count shifted left by 1. For the high octave, it SHALL be the middle-octave count shifted right by 1 (floor).
REQ-022 The divider counter SHALL be 19 bits wide and SHALL never overflow for any legal note/octave.
REQ-023 In TONE, the counter SHALL increment every cycle. When it equals half-1, it SHALL reset to 0 and speaker SHALL toggle.
REQ-024 The first speaker rise SHALL occur half cycles after entry to TONE or after a note change.
REQ-025 When enable rises while a valid note is held, the tone SHALL start from phase 0, with speaker low.
REQ-026 A note or octave change that is never accepted SHALL NOT affect speaker phase.

Reset
REQ-027 While reset=1, the following SHALL be applied on each edge: speaker=0, playing=0, cur_note=0, cur_octave=01, divider counter=0, stability counter=0, sample register=0, state=IDLE.
REQ-028 A reset asserted mid-tone SHALL force speaker=0 on the next edge. Input acceptance SHALL restart from zero after reset deasserts.

Structure
REQ-029 Package tone_pkg SHALL hold: the note code constants, the octave code constants, the seven middle-octave half-period constants, and the divider width constant (19).
REQ-030 Sub-module tone_input_filter SHALL implement REQ-011..013. Its outputs SHALL be an accept pulse and the accepted value.
REQ-031 The divider and the state machine SHALL be implemented in tone_gen.

Verification (STABLE_CYCLES=4 unless stated)
REQ-032 note_in=6, octave_in=01, enable=1, held -> accepted 3 edges after first sample; speaker period 227272 cycles, 50% duty; playing=1.
REQ-033 octave_in changed to 10, then to 00, with note 6 held -> half periods 56818 and 227272 respectively; speaker low immediately on each accept; octave 11 gives 113636.
REQ-034 note_in pulses to 2 for 2 cycles during a tone of note 6 -> cur_note stays 6; no phase break; speaker edges continue every 113636 cycles.
REQ-035 note_in=0 or 9 accepted -> cur_note=0, playing=0 on the next edge, speaker held 0.
REQ-036 enable=0 mid-tone, then enable=1 -> speaker 0 while disabled; first rise exactly half cycles after re-enable.
REQ-037 reset pulsed mid-tone with note 1 held -> speaker=0, cur_note=0, cur_octave=01; note 1 re-accepted 3 edges after reset deasserts; half period 191113.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants for the tone generator: note/octave codes, middle-octave
// half periods and the half-period lookup used by the divider.
package tone_pkg;

  localparam int DIV_W = 19;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SOL  = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;

  localparam logic [1:0] OCT_LOW     = 2'b00;
  localparam logic [1:0] OCT_MID     = 2'b01;
  localparam logic [1:0] OCT_HIGH    = 2'b10;
  localparam logic [1:0] OCT_MID_ALT = 2'b11;

  localparam logic [DIV_W-1:0] HALF_DO  = 19'd191113;
  localparam logic [DIV_W-1:0] HALF_RE  = 19'd170262;
  localparam logic [DIV_W-1:0] HALF_MI  = 19'd151686;
  localparam logic [DIV_W-1:0] HALF_FA  = 19'd143173;
  localparam logic [DIV_W-1:0] HALF_SOL = 19'd127551;
  localparam logic [DIV_W-1:0] HALF_LA  = 19'd113636;
  localparam logic [DIV_W-1:0] HALF_SI  = 19'd101239;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TONE = 1'b1
  } tone_state_e;

  function automatic logic note_valid(input logic [3:0] note);
    return (note >= NOTE_DO) && (note <= NOTE_SI);
  endfunction

  // Low octave doubles the middle count (max 382226, still fits 19 bits).
  function automatic logic [DIV_W-1:0] half_period(input logic [3:0] note,
                                                   input logic [1:0] octave);
    logic [DIV_W-1:0] mid;
    logic [DIV_W-1:0] res;
    case (note)
      NOTE_DO:  mid = HALF_DO;
      NOTE_RE:  mid = HALF_RE;
      NOTE_MI:  mid = HALF_MI;
      NOTE_FA:  mid = HALF_FA;
      NOTE_SOL: mid = HALF_SOL;
      NOTE_LA:  mid = HALF_LA;
      NOTE_SI:  mid = HALF_SI;
      default:  mid = '0;
    endcase
    case (octave)
      OCT_LOW:  res = mid << 1;
      OCT_HIGH: res = mid >> 1;
      default:  res = mid;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tone_input_filter.sv
// Debounces the {octave, note} request: a value is accepted on the
// STABLE_CYCLES-th consecutive edge it is sampled, with invalid notes mapped to rest.
module tone_input_filter
  import tone_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  output logic       accept,
  output logic [3:0] acc_note,
  output logic [1:0] acc_octave
);

  localparam logic [7:0] CNT_FULL = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [5:0] samp;
  logic [7:0] stab_cnt;
  logic [5:0] din;
  logic       same;

  assign din  = {octave_in, note_in};
  assign same = (din == samp);

  // stab_cnt holds how many consecutive edges samp has been seen; saturates
  // so a held value is accepted once only.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp     <= '0;
      stab_cnt <= '0;
    end else if (!same) begin
      samp     <= din;
      stab_cnt <= 8'd1;
    end else if (stab_cnt != CNT_FULL) begin
      stab_cnt <= stab_cnt + 8'd1;
    end
  end

  assign accept     = same && (stab_cnt == CNT_LAST);
  assign acc_note   = note_in[3] ? NOTE_REST : note_in;
  assign acc_octave = octave_in;

endmodule

// File: rtl/tone_gen.sv
// Square-wave buzzer driver: debounced note/octave select, IDLE/TONE control
// and a half-period divider toggling the speaker.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | muted or resting; speaker low, divider held at 0
//   ST_TONE | valid note enabled; divider runs and toggles speaker
module tone_gen
  import tone_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  input  logic       enable,
  output logic       speaker,
  output logic       playing,
  output logic [3:0] cur_note,
  output logic [1:0] cur_octave
);

  tone_state_e      state;
  tone_state_e      state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] half_cyc;
  logic             accept;
  logic [3:0]       acc_note;
  logic [1:0]       acc_octave;
  logic             new_value;
  logic             tone_run;
  logic             at_half;

  tone_input_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .note_in   (note_in),
    .octave_in (octave_in),
    .accept    (accept),
    .acc_note  (acc_note),
    .acc_octave(acc_octave)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (enable && note_valid(cur_note)) state_next = ST_TONE;
      ST_TONE: if (!enable || !note_valid(cur_note)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign half_cyc  = half_period(cur_note, cur_octave);
  assign new_value = accept && ({acc_octave, acc_note} != {cur_octave, cur_note});
  // Only count while staying in TONE, so muting silences on the same edge.
  assign tone_run  = (state == ST_TONE) && (state_next == ST_TONE);
  assign at_half   = (div_cnt == half_cyc - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      playing    <= 1'b0;
      cur_note   <= NOTE_REST;
      cur_octave <= OCT_MID;
      div_cnt    <= '0;
      speaker    <= 1'b0;
    end else begin
      state   <= state_next;
      playing <= (state_next == ST_TONE);
      if (new_value) begin
        cur_note   <= acc_note;
        cur_octave <= acc_octave;
        div_cnt    <= '0;
        speaker    <= 1'b0;
      end else if (!tone_run) begin
        div_cnt <= '0;
        speaker <= 1'b0;
      end else if (at_half) begin
        div_cnt <= '0;
        speaker <= ~speaker;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule
